// File: rtl/msg_tx_sched_pkg.sv
// Shared constants for the message transmit scheduler: state codes, framing
// characters and the per-requester frame templates.
package msg_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t WAIT = 2'd2;
  localparam state_t GAP  = 2'd3;

  localparam logic [7:0] HASH     = 8'h23;
  localparam logic [7:0] ARG_SLOT = 8'h3F;

  localparam int MAX_LEN = 11;

  // Templates are left-aligned: byte 0 of the frame is the most significant byte.
  localparam logic [8*MAX_LEN-1:0] TPL_FAULT = {"IFM-?-#", 32'h0};
  localparam logic [8*MAX_LEN-1:0] TPL_PICK  = "PBM-SU-B?-#";
  localparam logic [8*MAX_LEN-1:0] TPL_DROP  = "DBM-SU-B?-#";
  localparam logic [8*MAX_LEN-1:0] TPL_END   = {"END-#", 48'h0};

  function automatic logic [7:0] template_byte(input logic [1:0] req_id, input logic [3:0] idx);
    logic [8*MAX_LEN-1:0] tpl;
    logic [7:0]           b;
    case (req_id)
      2'd0:    tpl = TPL_FAULT;
      2'd1:    tpl = TPL_PICK;
      2'd2:    tpl = TPL_DROP;
      default: tpl = TPL_END;
    endcase
    // Out-of-range indices read as the terminator so a frame can never run on.
    b = HASH;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx == 4'(i)) b = tpl[8*(MAX_LEN-1-i) +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/msg_tx_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk_50M,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] win_idx;
  logic             found;

  always_comb begin
    base    = (ptr_reg == IDX_W'(NUM_REQ-1)) ? '0 : ptr_reg + 1'b1;
    win_idx = base;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[(int'(base) + i) % NUM_REQ]) begin
        found   = 1'b1;
        win_idx = IDX_W'((int'(base) + i) % NUM_REQ);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = found && (win_idx == IDX_W'(gi));
    end
  endgenerate

  // Pointer resets to the last slot so requester 0 is searched first.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n)
      ptr_reg <= IDX_W'(NUM_REQ-1);
    else if (en && found)
      ptr_reg <= win_idx;
  end

endmodule

// File: rtl/msg_tx_sched.sv
// Shares uart_tx among the message sources: grants round-robin, expands the
// granted template into a '#'-terminated frame and paces it byte by byte.
module msg_tx_sched
  import msg_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                 clk_50M,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] arg,
  input  logic                 tx_done,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  output logic [NUM_REQ-1:0]   ack,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t             state_reg;
  logic [3:0]         byte_idx_reg;
  logic [7:0]         arg_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [NUM_REQ-1:0] grant_oh;
  logic [1:0]         grant_idx;
  logic               arb_en;
  logic [7:0]         tpl_byte;
  logic [NUM_REQ-1:0] ack_vec;

  assign arb_en = (state_reg == IDLE) && (|req);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .req     (req),
    .en      (arb_en),
    .grant   (grant_oh)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) grant_idx = 2'(i);
    end
  end

  assign tpl_byte = template_byte(grant_id, byte_idx_reg);
  assign ack_vec  = NUM_REQ'(1) << grant_id;
  assign busy     = (state_reg != IDLE);

  // cnt_reg is the per-byte timeout timer in WAIT and the spacing counter in GAP.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      byte_idx_reg <= '0;
      arg_reg      <= '0;
      cnt_reg      <= '0;
      tx_data      <= 8'h00;
      tx_start     <= 1'b0;
      ack          <= '0;
      grant_id     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      ack         <= '0;
      timeout_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            grant_id     <= grant_idx;
            arg_reg      <= arg[8*grant_idx +: 8];
            byte_idx_reg <= '0;
            state_reg    <= LOAD;
          end
        end
        LOAD: begin
          tx_data   <= (tpl_byte == ARG_SLOT) ? arg_reg : tpl_byte;
          tx_start  <= 1'b1;
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          // A tx_done on the expiry cycle still counts as a normal completion.
          if (tx_done) begin
            if (tx_data == HASH) begin
              ack       <= ack_vec;
              cnt_reg   <= '0;
              state_reg <= GAP;
            end else begin
              byte_idx_reg <= byte_idx_reg + 4'd1;
              state_reg    <= LOAD;
            end
          end else if (cnt_reg == TMO_LAST) begin
            ack         <= ack_vec;
            timeout_err <= 1'b1;
            cnt_reg     <= '0;
            state_reg   <= GAP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (cnt_reg == GAP_LAST)
            state_reg <= IDLE;
          else
            cnt_reg <= cnt_reg + 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
